// File: rtl/perceptron_introduction.sv
// ---------------------------------------------------------------------------
// common_pkg
//   Shared types for the Common ML building blocks.
//   act_func : activation selector (Heaviside_Step, Sigmoid, ReLU).
// ---------------------------------------------------------------------------
package common_pkg;
    typedef enum logic [1:0] {
        Heaviside_Step = 2'd0,
        Sigmoid        = 2'd1,
        ReLU           = 2'd2
    } act_func;
endpackage

// ---------------------------------------------------------------------------
// perceptron_introduction
//   Single-neuron perceptron modelled with IEEE-754 double (`real`) maths.
//   After reset it trains on the train_values/expected table for `epochs`
//   passes, one sample per clock, using the classic perceptron rule. It then
//   drops `training` and registers act(b + w.values) every clock.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   values        in   real[size]       live feature vector for inference
//   activation    in   act_func         activation select
//   prediction    out  real             registered activation result
//   training      out  1                high until training completes
//   epochs        in   int              full passes over the table
//   learning_rate in   real             update step
//   train_values  in   real[num][size]  training samples
//   expected      in   real[num]        target per sample
//
// Training inputs are read live every cycle and must be held stable while
// `training` is high.
// ---------------------------------------------------------------------------
module perceptron_introduction
    import common_pkg::*;
#(
    parameter int size = 2,
    parameter int num  = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  real     values [size],
    input  act_func activation,
    output real     prediction,
    output logic    training,
    input  int      epochs,
    input  real     learning_rate,
    input  real     train_values [num][size],
    input  real     expected [num]
);

    localparam int IDX_W = (num > 1) ? $clog2(num) : 1;

    typedef enum logic {
        ST_TRAIN = 1'b0,
        ST_INFER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    real              w_q [size];
    real              w_d [size];
    real              b_q, b_d;
    real              pred_q, pred_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    int               epoch_q, epoch_d;

    // Scratch values for the current cycle's arithmetic.
    real z_v, y_v, err_v;

    function automatic real act_f(input real z, input act_func f);
        real r;
        case (f)
            Heaviside_Step: r = (z > 0.0) ? 1.0 : 0.0;
            Sigmoid:        r = 1.0 / (1.0 + $exp(-z));
            ReLU:           r = (z > 0.0) ? z : 0.0;
            default:        r = 0.0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_TRAIN;
            for (int k = 0; k < size; k++) begin
                w_q[k] <= 0.0;
            end
            b_q     <= 0.0;
            pred_q  <= 0.0;
            idx_q   <= '0;
            epoch_q <= 0;
        end else begin
            state_q <= state_d;
            for (int k = 0; k < size; k++) begin
                w_q[k] <= w_d[k];
            end
            b_q     <= b_d;
            pred_q  <= pred_d;
            idx_q   <= idx_d;
            epoch_q <= epoch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        for (int k = 0; k < size; k++) begin
            w_d[k] = w_q[k];
        end
        b_d     = b_q;
        pred_d  = pred_q;
        idx_d   = idx_q;
        epoch_d = epoch_q;
        z_v     = 0.0;
        y_v     = 0.0;
        err_v   = 0.0;

        case (state_q)
            ST_TRAIN: begin
                // Nothing to learn: leave training on the first edge with the
                // weights untouched.
                if (epochs <= 0 || num == 0) begin
                    state_d = ST_INFER;
                end else begin
                    z_v = b_q;
                    for (int k = 0; k < size; k++) begin
                        z_v = z_v + w_q[k] * train_values[idx_q][k];
                    end
                    y_v   = act_f(z_v, activation);
                    err_v = expected[idx_q] - y_v;
                    for (int k = 0; k < size; k++) begin
                        w_d[k] = w_q[k] + learning_rate * err_v * train_values[idx_q][k];
                    end
                    b_d = b_q + learning_rate * err_v;

                    if (idx_q == IDX_W'(num - 1)) begin
                        idx_d = '0;
                        // Last sample of the last epoch: this edge completes training.
                        if (epoch_q >= epochs - 1) begin
                            state_d = ST_INFER;
                        end else begin
                            epoch_d = epoch_q + 1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_INFER: begin
                z_v = b_q;
                for (int k = 0; k < size; k++) begin
                    z_v = z_v + w_q[k] * values[k];
                end
                pred_d = act_f(z_v, activation);
            end
            default: state_d = ST_TRAIN;
        endcase
    end

    assign prediction = pred_q;
    assign training   = (state_q == ST_TRAIN);

endmodule

// File: tb/tb_perceptron_introduction.sv
// Bench for perceptron_introduction: trains AND/OR/NAND/XOR tables and checks
// training length, inference results (Heaviside plus ReLU probes that expose
// the learned weights), asynchronous reset and the epochs<=0 corner.
module tb_perceptron_introduction;
    import common_pkg::*;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    real     values [2];
    act_func activation;
    real     prediction;
    logic    training;
    int      epochs;
    real     learning_rate;
    real     train_values [4][2];
    real     expected [4];

    int errors = 0;
    int checks = 0;

    perceptron_introduction #(.size(2), .num(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .values       (values),
        .activation   (activation),
        .prediction   (prediction),
        .training     (training),
        .epochs       (epochs),
        .learning_rate(learning_rate),
        .train_values (train_values),
        .expected     (expected)
    );

    always #5 clk = ~clk;

    typedef struct {
        int      gate;
        real     x0;
        real     x1;
        act_func act;
        real     exp_pred;
        real     tol;
    } vec_t;

    vec_t vecs[$];
    real  gate_exp [4][4];

    task automatic chk_real(input string name, input real act, input real exp, input real tol);
        checks++;
        if (act - exp > tol || exp - act > tol) begin
            errors++;
            $display("FAIL %s: got %f expected %f", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add_vec(input int g, input real x0, input real x1,
                                    input act_func a, input real e, input real tol);
        vec_t v;
        v.gate = g; v.x0 = x0; v.x1 = x1; v.act = a; v.exp_pred = e; v.tol = tol;
        vecs.push_back(v);
    endfunction

    // Load a gate's targets, pulse reset and check the reset state.
    task automatic start_training(input int g, input int ep);
        @(negedge clk);
        for (int i = 0; i < 4; i++) expected[i] = gate_exp[g][i];
        epochs        = ep;
        learning_rate = 1.0;
        activation    = Heaviside_Step;
        values[0]     = 1.0;
        values[1]     = 1.0;
        rst           = 1'b1;
        @(negedge clk);
        chk_int("reset_training", int'(training), 1);
        chk_real("reset_prediction", prediction, 0.0, 1e-9);
        rst = 1'b0;
    endtask

    // Count edges until training falls (bounded), checking prediction stays 0.
    task automatic wait_training(input string name, input int exp_edges);
        int n;
        n = 0;
        while (training && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 20 && training) chk_real("pred_held_during_training", prediction, 0.0, 1e-9);
        end
        chk_int(name, n, exp_edges);
    endtask

    task automatic apply(input real x0, input real x1, input act_func a);
        @(negedge clk);
        values[0]  = x0;
        values[1]  = x1;
        activation = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mism;
        // Sample order i0=(x1,x0)=(1,1), i1=(0,1), i2=(1,0), i3=(0,0); [i][0]=x0.
        train_values[0][0] = 1.0; train_values[0][1] = 1.0;
        train_values[1][0] = 1.0; train_values[1][1] = 0.0;
        train_values[2][0] = 0.0; train_values[2][1] = 1.0;
        train_values[3][0] = 0.0; train_values[3][1] = 0.0;
        gate_exp[0] = '{1.0, 0.0, 0.0, 0.0}; // AND
        gate_exp[1] = '{1.0, 1.0, 1.0, 0.0}; // OR
        gate_exp[2] = '{0.0, 1.0, 1.0, 1.0}; // NAND
        gate_exp[3] = '{0.0, 1.0, 1.0, 0.0}; // XOR
        values[0] = 0.0; values[1] = 0.0;
        activation = Heaviside_Step; epochs = 10; learning_rate = 1.0;
        expected = '{0.0, 0.0, 0.0, 0.0};

        // AND: w=(1,2), b=-2
        add_vec(0, 0.0, 0.0, Heaviside_Step, 0.0, 1e-9);
        add_vec(0, 1.0, 0.0, Heaviside_Step, 0.0, 1e-9);
        add_vec(0, 0.0, 1.0, Heaviside_Step, 0.0, 1e-9);
        add_vec(0, 1.0, 1.0, Heaviside_Step, 1.0, 1e-9);
        add_vec(0, 10.0, 0.0, ReLU, 8.0, 1e-9);
        add_vec(0, 0.0, 10.0, ReLU, 18.0, 1e-9);
        add_vec(0, 1.0, 1.0, ReLU, 1.0, 1e-9);
        add_vec(0, 1.0, 1.0, Sigmoid, 0.7311, 1e-4);
        // OR: w=(1,1), b=0
        add_vec(1, 0.0, 0.0, Heaviside_Step, 0.0, 1e-9);
        add_vec(1, 1.0, 0.0, Heaviside_Step, 1.0, 1e-9);
        add_vec(1, 0.0, 1.0, Heaviside_Step, 1.0, 1e-9);
        add_vec(1, 1.0, 1.0, Heaviside_Step, 1.0, 1e-9);
        add_vec(1, 10.0, 0.0, ReLU, 10.0, 1e-9);
        add_vec(1, 10.0, 10.0, ReLU, 20.0, 1e-9);
        // NAND: w=(-1,-2), b=3
        add_vec(2, 0.0, 0.0, Heaviside_Step, 1.0, 1e-9);
        add_vec(2, 1.0, 0.0, Heaviside_Step, 1.0, 1e-9);
        add_vec(2, 0.0, 1.0, Heaviside_Step, 1.0, 1e-9);
        add_vec(2, 1.0, 1.0, Heaviside_Step, 0.0, 1e-9);
        add_vec(2, 0.0, 0.0, ReLU, 3.0, 1e-9);
        add_vec(2, -10.0, 0.0, ReLU, 13.0, 1e-9);
        add_vec(2, 0.0, -10.0, ReLU, 23.0, 1e-9);

        for (int g = 0; g < 3; g++) begin
            start_training(g, 10);
            wait_training($sformatf("train_edges_g%0d", g), 40);
            foreach (vecs[i]) begin
                if (vecs[i].gate == g) begin
                    apply(vecs[i].x0, vecs[i].x1, vecs[i].act);
                    chk_real($sformatf("pred_g%0d_v%0d", g, i), prediction, vecs[i].exp_pred, vecs[i].tol);
                end
            end
        end

        // XOR: runs full length, cannot be learned exactly.
        start_training(3, 10);
        wait_training("train_edges_xor", 40);
        mism = 0;
        for (int i = 0; i < 4; i++) begin
            apply(train_values[i][0], train_values[i][1], Heaviside_Step);
            if (prediction != gate_exp[3][i]) mism++;
        end
        checks++;
        if (mism < 1) begin
            errors++;
            $display("FAIL xor_mismatch: got %0d mismatches expected at least 1", mism);
        end

        // Asynchronous reset at edge 15 of AND training, then a clean retrain.
        start_training(0, 10);
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_int("midtrain_rst_training", int'(training), 1);
        chk_real("midtrain_rst_prediction", prediction, 0.0, 1e-9);
        @(negedge clk);
        rst = 1'b0;
        wait_training("retrain_edges", 40);
        apply(10.0, 10.0, ReLU);
        chk_real("retrain_relu_10_10", prediction, 28.0, 1e-9);
        apply(10.0, 0.0, ReLU);
        chk_real("retrain_relu_10_0", prediction, 8.0, 1e-9);

        // Asynchronous reset during inference clears the prediction at once.
        apply(1.0, 1.0, Heaviside_Step);
        chk_real("pre_rst_pred", prediction, 1.0, 1e-9);
        #2 rst = 1'b1;
        #1;
        chk_real("infer_rst_prediction", prediction, 0.0, 1e-9);
        chk_int("infer_rst_training", int'(training), 1);
        @(negedge clk);

        // epochs=0 and negative epochs: training ends after one edge, weights stay 0.
        start_training(0, 0);
        wait_training("epochs0_edges", 1);
        apply(1.0, 1.0, Heaviside_Step);
        chk_real("epochs0_heaviside", prediction, 0.0, 1e-9);
        apply(5.0, 7.0, ReLU);
        chk_real("epochs0_relu", prediction, 0.0, 1e-9);
        apply(5.0, 7.0, Sigmoid);
        chk_real("epochs0_sigmoid", prediction, 0.5, 1e-9);
        start_training(0, -3);
        wait_training("epochs_neg_edges", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
